// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS debug controller: FSM states, command bytes
// and status bytes.
package mips_debug_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_RUN,
    S_LOAD,
    S_SEND,
    S_TAIL
  } state_e;

  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  localparam logic [7:0] ST_END = 8'hA5;
  localparam logic [7:0] ST_RUN = 8'h5A;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/dbg_word_serializer.sv
// Loads a 32-bit word and hands it out MSB byte first over a valid/ready port.
// A single-byte load sends only load_word[31:24].
module dbg_word_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        load_single,
  input  logic [31:0] load_word,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_byte
);

  logic [31:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    // A new load wins over an acceptance of the final byte in the same cycle.
    if (load) begin
      sr_d    = load_word;
      cnt_d   = load_single ? 2'd0 : 2'd3;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready) begin
      if (cnt_q == 2'd0) begin
        valid_d = 1'b0;
      end else begin
        sr_d  = {sr_q[23:0], 8'h00};
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data   = sr_q[31:24];
  assign tx_valid  = valid_q;
  assign last_byte = valid_q && (cnt_q == 2'd0);

endmodule

// File: rtl/mips_debug_controller.sv
// Debug controller: decodes UART commands, gates the core clock-enable and
// dumps PC, register file and a data-memory window as a byte frame.
module mips_debug_controller
  import mips_debug_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int RD_WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        core_ena,
  output logic [4:0]  du_areg,
  output logic        du_regsel,
  output logic [31:0] du_amem,
  output logic        du_memsel,
  input  logic [31:0] core_pc,
  input  logic [31:0] core_regdata,
  input  logic [31:0] core_memdata,
  input  logic        core_pc_end,
  output logic        busy
);

  localparam int          WAIT_W  = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [8:0]  LAST_W  = 9'(NUM_REGS + MEM_WORDS);
  localparam logic [8:0]  REG_TOP = 9'(NUM_REGS);

  state_e              state_q, state_d;
  logic [8:0]          w_q, w_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                core_ena_q, core_ena_d;
  logic [4:0]          areg_q, areg_d;
  logic [31:0]         amem_q, amem_d;
  logic                regsel_q, regsel_d;
  logic                memsel_q, memsel_d;
  logic                busy_q, busy_d;

  logic                ser_load, ser_single, ser_last;
  logic [31:0]         ser_word;
  logic [8:0]          mem_idx;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    wait_d     = wait_q;
    core_ena_d = 1'b0;
    areg_d     = areg_q;
    amem_d     = amem_q;
    ser_load   = 1'b0;
    ser_single = 1'b0;
    if (w_q == 9'd0)          ser_word = core_pc;
    else if (w_q <= REG_TOP)  ser_word = core_regdata;
    else                      ser_word = core_memdata;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_STEP: begin
              state_d    = S_STEP;
              core_ena_d = !core_pc_end;
            end
            CMD_CONT: begin
              state_d    = S_RUN;
              core_ena_d = !core_pc_end;
            end
            CMD_DUMP: begin
              state_d = S_LOAD;
              w_d     = 9'd0;
            end
            default: ;
          endcase
        end
      end
      S_STEP: begin
        state_d = S_LOAD;
        w_d     = 9'd0;
      end
      S_RUN: begin
        if (core_pc_end) begin
          state_d = S_LOAD;
          w_d     = 9'd0;
        end else begin
          core_ena_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (wait_q == '0) begin
          ser_load = 1'b1;
          state_d  = S_SEND;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_SEND: begin
        if (ser_last && tx_ready) begin
          if (w_q == LAST_W) begin
            state_d    = S_TAIL;
            ser_load   = 1'b1;
            ser_single = 1'b1;
            ser_word   = {(core_pc_end ? ST_END : ST_RUN), 24'h0};
          end else begin
            w_d     = w_q + 9'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_TAIL: begin
        if (ser_last && tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Addresses update on LOAD entry so the read wait starts with them.
    mem_idx = w_d - 9'd33;
    if (state_d == S_LOAD && state_q != S_LOAD) begin
      wait_d = WAIT_W'(RD_WAIT - 1);
      if (w_d >= 9'd1 && w_d <= REG_TOP) areg_d = w_d[4:0] - 5'd1;
      if (w_d > REG_TOP)                 amem_d = {21'd0, mem_idx, 2'b00};
    end

    regsel_d = (state_d == S_LOAD || state_d == S_SEND) && (w_d >= 9'd1) && (w_d <= REG_TOP);
    memsel_d = (state_d == S_LOAD || state_d == S_SEND) && (w_d > REG_TOP);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      wait_q     <= '0;
      core_ena_q <= 1'b0;
      areg_q     <= '0;
      amem_q     <= '0;
      regsel_q   <= 1'b0;
      memsel_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      wait_q     <= wait_d;
      core_ena_q <= core_ena_d;
      areg_q     <= areg_d;
      amem_q     <= amem_d;
      regsel_q   <= regsel_d;
      memsel_q   <= memsel_d;
      busy_q     <= busy_d;
    end
  end

  dbg_word_serializer u_ser (
    .clk         (clk),
    .reset       (reset),
    .load        (ser_load),
    .load_single (ser_single),
    .load_word   (ser_word),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .last_byte   (ser_last)
  );

  assign core_ena  = core_ena_q;
  assign du_areg   = areg_q;
  assign du_amem   = amem_q;
  assign du_regsel = regsel_q;
  assign du_memsel = memsel_q;
  assign busy      = busy_q;

endmodule
